mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Microcoded-style datapath controller: fetch/decode/execute FSM with memory wait timeout.
// Optional stack instructions (PUSH/POP) enabled by defining MC_STACK_OPS_EN.
module mc_controller #(
   parameter int unsigned OPW    = 4,
   parameter int unsigned FNW    = 3,
   parameter int unsigned TMO    = 15,
   parameter int unsigned FN_INC = 1,
   parameter int unsigned FN_DEC = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [OPW-1:0] ir1,
   input  logic [FNW-1:0] ir2,
   input  logic           dcond,
   input  logic           memrdy,
   output logic           memwr,
   output logic           memrd,
   output logic           tmar,
   output logic           ldmar,
   output logic           tmdr,
   output logic           ldmdr,
   output logic           rd,
   output logic           wr,
   output logic           tsp,
   output logic           ldsp,
   output logic           tpc,
   output logic           ldpc,
   output logic           tir,
   output logic           ldir,
   output logic           ldt,
   output logic           m1,
   output logic           m2,
   output logic [FNW-1:0] fnsel,
   output logic           halted,
   output logic           err
);

   localparam int unsigned CW    = 8;
   localparam logic [CW-1:0] TMO_C = CW'(TMO);

   typedef enum logic [4:0] {
      ST_IDLE, ST_F0, ST_F1, ST_F2, ST_DEC,
      ST_A0, ST_A1,
      ST_L0, ST_L1, ST_L2,
      ST_S0, ST_S1, ST_S2,
      ST_J0, ST_HALT
`ifdef MC_STACK_OPS_EN
      , ST_P0, ST_P1, ST_P2, ST_P3,
      ST_Q0, ST_Q1, ST_Q2, ST_Q3
`endif
   } state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic          err_q;
   logic [31:0]   op_ext;

   assign op_ext = 32'(ir1);
   assign err    = err_q;

`ifndef MC_STACK_OPS_EN
   logic unused_fn;
   assign unused_fn = ^{FNW'(FN_INC), FNW'(FN_DEC)};
`endif

   // Successor of each memory wait state once memrdy arrives.
   function automatic state_e wait_next(input state_e s);
      case (s)
         ST_F1:   wait_next = ST_F2;
         ST_L1:   wait_next = ST_L2;
`ifdef MC_STACK_OPS_EN
         ST_P2:   wait_next = ST_P3;
         ST_Q2:   wait_next = ST_Q3;
`endif
         default: wait_next = ST_F0;
      endcase
   endfunction

   // State, wait counter and registered error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         cnt_q <= '0;
         case (state_q)
            ST_IDLE: state_q <= ST_F0;
            ST_F0:   state_q <= ST_F1;
            ST_F2:   state_q <= ST_DEC;
            ST_DEC: begin
               case (op_ext)
                  32'd0:   state_q <= ST_A0;
                  32'd1:   state_q <= ST_L0;
                  32'd2:   state_q <= ST_S0;
                  32'd3:   state_q <= dcond ? ST_J0 : ST_F0;
                  32'd4:   state_q <= ST_J0;
`ifdef MC_STACK_OPS_EN
                  32'd5:   state_q <= ST_P0;
                  32'd6:   state_q <= ST_Q0;
`endif
                  32'd7:   state_q <= ST_HALT;
                  default: begin
                     state_q <= ST_F0;
                     err_q   <= 1'b1;
                  end
               endcase
            end
            ST_A0:   state_q <= ST_A1;
            ST_L0:   state_q <= ST_L1;
            ST_S0:   state_q <= ST_S1;
            ST_S1:   state_q <= ST_S2;
`ifdef MC_STACK_OPS_EN
            ST_P0:   state_q <= ST_P1;
            ST_P1:   state_q <= ST_P2;
            ST_Q0:   state_q <= ST_Q1;
            ST_Q1:   state_q <= ST_Q2;
            ST_F1, ST_L1, ST_S2, ST_P2, ST_Q2: begin
`else
            ST_F1, ST_L1, ST_S2: begin
`endif
               // memrdy wins even on the cycle the count sits at TMO
               if (memrdy) begin
                  state_q <= wait_next(state_q);
               end else if (cnt_q == TMO_C) begin
                  state_q <= ST_HALT;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_HALT: state_q <= ST_HALT;
            default: state_q <= ST_F0;
         endcase
      end
   end

   // Datapath controls decoded from the current state.
   always_comb begin
      memwr  = 1'b0;
      memrd  = 1'b0;
      tmar   = 1'b0;
      ldmar  = 1'b0;
      tmdr   = 1'b0;
      ldmdr  = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      tsp    = 1'b0;
      ldsp   = 1'b0;
      tpc    = 1'b0;
      ldpc   = 1'b0;
      tir    = 1'b0;
      ldir   = 1'b0;
      ldt    = 1'b0;
      m1     = 1'b0;
      m2     = 1'b0;
      fnsel  = '0;
      halted = 1'b0;
      case (state_q)
         ST_F0: begin tpc = 1'b1; ldmar = 1'b1; end
         ST_F1: begin memrd = 1'b1; ldmdr = memrdy; end
         ST_F2: begin tmdr = 1'b1; ldir = 1'b1; ldpc = 1'b1; m1 = 1'b1; end
         ST_A0: begin rd = 1'b1; ldt = 1'b1; end
         ST_A1: begin rd = 1'b1; wr = 1'b1; fnsel = ir2; end
         ST_L0: begin tir = 1'b1; ldmar = 1'b1; end
         ST_L1: begin memrd = 1'b1; ldmdr = memrdy; end
         ST_L2: begin tmdr = 1'b1; wr = 1'b1; end
         ST_S0: begin tir = 1'b1; ldmar = 1'b1; end
         ST_S1: begin rd = 1'b1; ldmdr = 1'b1; m2 = 1'b1; end
         ST_S2: memwr = 1'b1;
         ST_J0: begin tir = 1'b1; ldpc = 1'b1; end
`ifdef MC_STACK_OPS_EN
         ST_P0: begin tsp = 1'b1; ldmar = 1'b1; end
         ST_P1: begin rd = 1'b1; ldmdr = 1'b1; m2 = 1'b1; end
         ST_P2: memwr = 1'b1;
         ST_P3: begin tsp = 1'b1; ldsp = 1'b1; fnsel = FNW'(FN_DEC); end
         ST_Q0: begin tsp = 1'b1; ldsp = 1'b1; fnsel = FNW'(FN_INC); end
         ST_Q1: begin tsp = 1'b1; ldmar = 1'b1; end
         ST_Q2: begin memrd = 1'b1; ldmdr = memrdy; end
         ST_Q3: begin tmdr = 1'b1; wr = 1'b1; end
`endif
         ST_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule
